dp_ram_be: RTL

Parametrised true dual-port synchronous RAM with per-byte write enables and a selectable read-during-write mode. It also has an optional output pipeline register, per-port read-valid strobes, and same-address write-collision detection. After every reset, a hardware clear sequencer zeroes the whole array. It is the general-purpose storage primitive for packet buffers and register files that need two independent access ports.

---
 rtl/dp_ram_be.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte write enables, selectable same-port read-during-write,
// optional output register, collision flag and a post-reset zero-fill sequencer.
module dp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_a,
    input  logic [DATA_WIDTH/8-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   data_in_a,
    output logic [DATA_WIDTH-1:0]   data_out_a,
    output logic                    valid_a,
    input  logic                    en_b,
    input  logic [DATA_WIDTH/8-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   data_in_b,
    output logic [DATA_WIDTH-1:0]   data_out_b,
    output logic                    valid_b,
    output logic                    busy,
    output logic                    collision
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic acc_a, acc_b, same_addr;
    logic [NBYTES-1:0] wr_a, wr_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b, rd_word_a, rd_word_b;
    logic [DATA_WIDTH-1:0] d1_a, d1_b;
    logic v1_a, v1_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_addr == {ADDR_WIDTH{1'b1}})
            state_next = READY;
    end

    assign busy      = (state == CLEAR);
    assign acc_a     = en_a && (state == READY);
    assign acc_b     = en_b && (state == READY);
    assign same_addr = (addr_a == addr_b);

    // Port A owns every byte both ports enable on a shared address.
    assign wr_a = acc_a ? we_a : '0;
    assign wr_b = acc_b ? (same_addr ? (we_b & ~wr_a) : we_b) : '0;

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wr_a[k])
                    mem[addr_a][8*k +: 8] <= data_in_a[8*k +: 8];
                if (wr_b[k])
                    mem[addr_b][8*k +: 8] <= data_in_b[8*k +: 8];
            end
        end
    end

    // Write-first merges only the port's own bytes; the other port always sees old data.
    always_comb begin
        old_a    = mem[addr_a];
        old_b    = mem[addr_b];
        merged_a = old_a;
        merged_b = old_b;
        for (int k = 0; k < NBYTES; k++) begin
            if (we_a[k])
                merged_a[8*k +: 8] = data_in_a[8*k +: 8];
            if (we_b[k])
                merged_b[8*k +: 8] = data_in_b[8*k +: 8];
        end
        rd_word_a = (RDW_MODE != 0) ? merged_a : old_a;
        rd_word_b = (RDW_MODE != 0) ? merged_b : old_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_a      <= '0;
            d1_b      <= '0;
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            v1_a      <= acc_a;
            v1_b      <= acc_b;
            collision <= acc_a && acc_b && same_addr && ((we_a & we_b) != '0);
            if (acc_a)
                d1_a <= rd_word_a;
            if (acc_b)
                d1_b <= rd_word_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] d2_a, d2_b;
            logic v2_a, v2_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d2_a <= '0;
                    d2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a)
                        d2_a <= d1_a;
                    if (v1_b)
                        d2_b <= d1_b;
                end
            end

            assign data_out_a = d2_a;
            assign data_out_b = d2_b;
            assign valid_a    = v2_a;
            assign valid_b    = v2_b;
        end else begin : g_no_out_reg
            assign data_out_a = d1_a;
            assign data_out_b = d1_b;
            assign valid_a    = v1_a;
            assign valid_b    = v1_b;
        end
    endgenerate

endmodule
